// File: rtl/serial_adder_ctrl_if.sv
// Handshake/bus bundle for serial_adder_ctrl.
//   master: drives start, a, b, carry_in; observes busy, done, sum, carry_out
//   slave : the adder controller itself
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, carry_out
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder slice is reused over WIDTH
// clocks, LSB first, to form {carry_out, sum} = a + b + carry_in.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, clears all state
//   bus  - serial_adder_ctrl_if.slave
//          start/a/b/carry_in in; busy (RUN), done (1-cycle strobe),
//          sum/carry_out (registered result, held until next completion) out
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb, acc;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             accept;
  logic             last_bit;
  logic [1:0]       ha0, ha1;
  logic             s_bit;
  logic             c_nxt;

  // Half adder: {carry, sum}
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Full-adder slice built from two half adders plus carry OR
  always_comb begin
    ha0   = half_add(opa[0], opb[0]);
    ha1   = half_add(ha0[0], c);
    s_bit = ha1[0];
    c_nxt = ha0[1] | ha1[1];
  end

  assign accept   = bus.start && (state == IDLE || state == DONE);
  assign last_bit = (state == RUN) && (cnt == LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start during RUN is deliberately ignored
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode only from the state register, never from inputs
  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  // Datapath: operand shift registers, carry flop, accumulator, counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      opa <= bus.a;
      opb <= bus.b;
      c   <= bus.carry_in;
      cnt <= '0;
    end else if (state == RUN) begin
      opa <= {1'b0, opa[WIDTH-1:1]};
      opb <= {1'b0, opb[WIDTH-1:1]};
      c   <= c_nxt;
      acc <= {s_bit, acc[WIDTH-1:1]};
      cnt <= cnt + 1'b1;
      // Final bit: publish the result including this edge's sum bit/carry
      if (last_bit) begin
        sum_q  <= {s_bit, acc[WIDTH-1:1]};
        cout_q <= c_nxt;
      end
    end
  end

  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int W  = 8;
  localparam int W1 = W + 1;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain unsigned arithmetic on the full operands
  function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
    return {1'b0, a} + {1'b0, b} + W1'(cin);
  endfunction

  // Stimulus-only: issue one operation, then observe W+4 samples after the
  // accepting edge (sample i is taken #1 after edge k+i).
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          output int busy_cyc, output int done_at, output int done_cnt,
                          output logic [W-1:0] s, output logic co,
                          output bit held, output bit overlap);
    logic [W-1:0] prev;
    prev = bus.sum;
    bus.a = a; bus.b = b; bus.carry_in = cin; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.carry_in = 1'($urandom);
    busy_cyc = 0; done_at = -1; done_cnt = 0; s = '0; co = 1'b0; held = 1; overlap = 0;
    for (int i = 0; i <= W + 3; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (bus.busy) busy_cyc++;
      if (bus.busy && bus.done) overlap = 1;
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) begin done_at = i; s = bus.sum; co = bus.carry_out; end
      end else if (done_at < 0 && bus.sum !== prev) held = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.carry_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.sum !== '0) begin n_err++; $display("FAIL reset_sum: got %h want 00", bus.sum); end
    n_cmp++; if (bus.carry_out !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b want 0", bus.carry_out); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++; $display("FAIL idle_after_reset: busy=%b done=%b want 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_arith();
    logic [W-1:0] ta [3];
    logic [W-1:0] tb [3];
    logic         tc [3];
    logic [W-1:0] a, b, s;
    logic         cin, co;
    logic [W:0]   exp;
    int           busy_cyc, done_at, done_cnt;
    bit           held, overlap;
    ta[0] = 8'h03; tb[0] = 8'h05; tc[0] = 1'b0;
    ta[1] = 8'hFF; tb[1] = 8'h01; tc[1] = 1'b0;
    ta[2] = 8'hA5; tb[2] = 8'h5A; tc[2] = 1'b1;
    for (int n = 0; n < 23; n++) begin
      if (n < 3) begin a = ta[n]; b = tb[n]; cin = tc[n]; end
      else begin a = W'($urandom); b = W'($urandom); cin = 1'($urandom); end
      // Leave 0..2 idle cycles between operations
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      exp = model_add(a, b, cin);
      drive_op(a, b, cin, busy_cyc, done_at, done_cnt, s, co, held, overlap);
      n_cmp++; if ({co, s} !== exp) begin
        n_err++; $display("FAIL sum[%0d] %h+%h+%b: got %b_%h want %b_%h", n, a, b, cin, co, s, exp[W], exp[W-1:0]);
      end
      n_cmp++; if (busy_cyc != W) begin n_err++; $display("FAIL busy_len[%0d]: got %0d want %0d", n, busy_cyc, W); end
      n_cmp++; if (done_at != W) begin n_err++; $display("FAIL done_time[%0d]: got %0d want %0d", n, done_at, W); end
      n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL done_count[%0d]: got %0d want 1", n, done_cnt); end
      n_cmp++; if (!held) begin n_err++; $display("FAIL sum_hold[%0d]: got changed want held", n); end
      n_cmp++; if (overlap) begin n_err++; $display("FAIL busy_done_overlap[%0d]: got 1 want 0", n); end
    end
  endtask

  task automatic test_ignore_start();
    int done_at, done_cnt;
    logic [W-1:0] s;
    bus.a = 8'h10; bus.b = 8'h20; bus.carry_in = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    done_at = -1; done_cnt = 0; s = '0;
    for (int i = 0; i <= 2 * W + 2; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i == 2) begin bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; end
      if (i == 3) bus.start = 1'b0;
      if (bus.done) begin done_cnt++; if (done_at < 0) begin done_at = i; s = bus.sum; end end
    end
    n_cmp++; if (done_at != W) begin n_err++; $display("FAIL ignore_done_time: got %0d want %0d", done_at, W); end
    n_cmp++; if (s !== 8'h30) begin n_err++; $display("FAIL ignore_sum: got %h want 30", s); end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_abort();
    int busy_seen, done_seen, done_at;
    logic [W-1:0] s;
    bus.a = 8'h10; bus.b = 8'h22; bus.carry_in = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.sum !== '0) begin n_err++; $display("FAIL abort_sum: got %h want 00", bus.sum); end
    n_cmp++; if (bus.carry_out !== 1'b0) begin n_err++; $display("FAIL abort_cout: got %b want 0", bus.carry_out); end
    @(posedge clk); #1;
    rst = 1'b0;
    busy_seen = 0; done_seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_seen++;
      if (bus.done) done_seen++;
    end
    n_cmp++; if (done_seen != 0 || busy_seen != 0) begin
      n_err++; $display("FAIL abort_quiet: got busy=%0d done=%0d want 0/0", busy_seen, done_seen);
    end
    // Start already high when reset releases: accepted on the first edge
    rst = 1'b1;
    bus.a = 8'h21; bus.b = 8'h43; bus.carry_in = 1'b1; bus.start = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL release_accept: got busy=%b want 1", bus.busy); end
    done_at = -1; s = '0;
    for (int i = 1; i <= W + 2; i++) begin
      @(posedge clk); #1;
      if (bus.done && done_at < 0) begin done_at = i; s = bus.sum; end
    end
    n_cmp++; if (done_at != W) begin n_err++; $display("FAIL release_done_time: got %0d want %0d", done_at, W); end
    n_cmp++; if (s !== 8'h65) begin n_err++; $display("FAIL release_sum: got %h want 65", s); end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    bit held;
    logic [W:0] first;
    first = model_add(8'h12, 8'h34, 1'b0);
    bus.a = 8'h12; bus.b = 8'h34; bus.carry_in = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    d1 = -1; d2 = -1; held = 1;
    for (int i = 0; i <= 2 * W + 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (bus.done) begin
        if (d1 < 0) d1 = i;
        else if (d2 < 0) begin
          d2 = i;
          n_cmp++; if ({bus.carry_out, bus.sum} !== 9'h080) begin
            n_err++; $display("FAIL b2b_sum2: got %b_%h want 0_80", bus.carry_out, bus.sum);
          end
        end
      end
      if (d1 >= 0 && d2 < 0 && {bus.carry_out, bus.sum} !== first) held = 0;
      if (i == W) begin bus.start = 1'b1; bus.a = 8'h7F; bus.b = 8'h01; bus.carry_in = 1'b0; end
      if (i == W + 1) bus.start = 1'b0;
    end
    n_cmp++; if (d1 != W) begin n_err++; $display("FAIL b2b_done1: got %0d want %0d", d1, W); end
    n_cmp++; if (d2 - d1 != W + 1) begin n_err++; $display("FAIL b2b_spacing: got %0d want %0d", d2 - d1, W + 1); end
    n_cmp++; if (!held) begin n_err++; $display("FAIL b2b_hold: got changed want first result held"); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences a single one-bit full-adder slice (two half-adder stages plus carry OR) over a WIDTH-bit operand pair, LSB first, one bit per clock. It latches operands on a start pulse and runs the slice for WIDTH cycles with a registered carry. It then presents a registered WIDTH-bit sum and carry-out with a one-cycle done strobe. It lets small-area designs share one adder slice instead of instantiating a WIDTH-bit ripple adder.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset; clears all state immediately.
- Start  input  1  request; sampled on rising Clk; accepted only in IDLE or DONE.
- A  input  WIDTH  operand A; captured on the accepting edge only.
- B  input  WIDTH  operand B; captured on the accepting edge only.
- CarryIn  input  1  initial carry; captured with A/B.
- Busy  output  1  high while in RUN.
- Done  output  1  one-cycle strobe; Sum/CarryOut are valid from this cycle on.
- Sum  output  WIDTH  registered result; holds until the next completion.
- CarryOut  output  1  registered final carry; holds with Sum.

## Operation
- One clock domain. Reset is asynchronous and active-high.
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE + Start: capture A, B, CarryIn into shift registers opA, opB and carry flop c. Clear bit counter cnt and go to RUN.
- RUN, each edge:
  - s = opA[0]^opB[0]^c.
  - c <= opA[0]&opB[0] | c&(opA[0]^opB[0]).
  - opA, opB shift right by 1.
  - s shifts into acc from the MSB end.
  - cnt increments.
- RUN with cnt==WIDTH-1: process the final bit and go to DONE.
  - On that same edge, load Sum with the completed accumulator, including that edge's s bit.
  - On that same edge, load CarryOut with that edge's carry.
- DONE: Done=1 for exactly one cycle.
  - DONE + Start: capture new operands and go to RUN (back-to-back).
  - Otherwise go to IDLE.
- Start in RUN is ignored: no capture, no restart, no queuing.
- Sum/CarryOut change only on a completion edge. They stay stable through later IDLE and RUN periods.
- Arithmetic: {CarryOut, Sum} = A + B + CarryIn, as a WIDTH+1-bit unsigned result.
- cnt width is clog2(WIDTH)+1 bits. cnt never wraps inside an operation.
- Reset asserted mid-operation aborts the operation. No Done is produced for the aborted operation.

## Timing
- Reset values: Busy=0, Done=0, Sum=0, CarryOut=0, state=IDLE.
- Internal opA, opB, acc, c and cnt also reset to 0.
- Let the accepting edge be edge k.
  - Busy=1 from after edge k through the cycle ending at edge k+WIDTH.
  - Done=1 in the cycle after edge k+WIDTH.
  - Latency from Start to Done is WIDTH+1 cycles.
- Back-to-back throughput: one result per WIDTH+1 cycles (Start asserted during DONE).
- Busy and Done are never high in the same cycle.
- All outputs are registered. There is no combinational path from any input to any output.
- Reset deasserted with Start already high: Start is accepted on the first rising edge after deassertion.

## Test plan
- 8'h03 + 8'h05, CarryIn=0, Start at edge k:
  - Busy high for 8 cycles.
  - Done in cycle k+9.
  - Sum=8'h08, CarryOut=0.
- 8'hFF + 8'h01, CarryIn=0 -> Sum=8'h00, CarryOut=1.
- 8'hA5 + 8'h5A, CarryIn=1 -> Sum=8'h00, CarryOut=1.
- Start pulsed 3 cycles into an 8'h10 + 8'h20 run, with A=8'hFF and B=8'hFF presented on that pulse:
  - The pulse is ignored.
  - Done still lands at k+9.
  - Sum=8'h30.
  - No second Done follows.
- Reset asserted 4 cycles into a run:
  - Busy, Done, Sum and CarryOut go to 0 immediately, without waiting for a clock edge.
  - After release, no Done appears until a new Start is given.
- Back-to-back: Start held during DONE with 8'h7F + 8'h01:
  - Second Done arrives 9 cycles after the first.
  - Sum=8'h80, CarryOut=0.
  - The first result holds on Sum until the second completion edge.
